wb_register_file: RTL and testbench
===================================

Name: wb_register_file

Overview:
- Receiving end of the writeback stage: the 32-entry general-purpose register file.
- Accepts the writeback mux result (RegWrite, destination address, data) and serves the two decode-stage read ports.
- Same-cycle write-to-read bypass is built in.
- A ready/valid dump sequencer streams all registers, one per accepted beat, to the debug unit.

Parameters:
- NB_DATA, 32, register and data width
- NB_ADDR, 5, register address width
- N_REGS, 32, number of registers (equals 2**NB_ADDR)

Ports:
- i_clk  in  1  system clock, rising-edge active
- i_reset  in  1  synchronous, active-high reset
- i_wr_enable  in  1  RegWrite from writeback
- i_wr_addr  in  NB_ADDR  destination register from writeback
- i_wr_data  in  NB_DATA  writeback mux output
- i_rd_addr_a  in  NB_ADDR  read port A address (rs)
- i_rd_addr_b  in  NB_ADDR  read port B address (rt)
- o_rd_data_a  out  NB_DATA  read port A data
- o_rd_data_b  out  NB_DATA  read port B data
- i_dump_start  in  1  request a full register dump
- i_dump_ready  in  1  debug unit accepts the current beat
- o_dump_valid  out  1  dump beat valid
- o_dump_addr  out  NB_ADDR  index of the register in the current beat
- o_dump_data  out  NB_DATA  value of the register in the current beat
- o_dump_busy  out  1  dump in progress
- o_dump_done  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset, sampled on the i_clk rising edge while i_reset=1:
  - All registers cleared to 0.
  - FSM goes to IDLE; o_dump_valid, o_dump_busy, o_dump_done = 0; o_dump_addr and o_dump_data = 0.
  - Reset wins over every other input in the same cycle.
- Write:
  - On a rising edge with i_wr_enable=1 and i_wr_addr!=0, regs[i_wr_addr] <= i_wr_data.
  - Writes to register 0 are discarded; register 0 always reads 0.
- Read (combinational, zero latency):
  - o_rd_data_x = 0 when addr=0.
  - Otherwise o_rd_data_x = i_wr_data when i_wr_enable=1 and i_wr_addr==addr (bypass).
  - Otherwise o_rd_data_x = regs[addr].
  - Both ports are independent and may hit the same address.
- Writes are accepted in every FSM state; the dump never blocks writeback.
- Dump FSM, three states:
  - IDLE: busy=0, valid=0. When i_dump_start=1, move to SEND with idx=0, latch o_dump_addr=0 and o_dump_data=regs[0]=0, assert valid.
  - SEND: busy=1, valid=1.
    - o_dump_addr and o_dump_data are registered and hold stable until i_dump_ready=1.
    - On valid&ready with idx<N_REGS-1: idx increments, and o_dump_addr/o_dump_data load the next index and the stored regs value at that edge. A write landing on the same edge is not visible in that beat.
    - On valid&ready with idx==N_REGS-1: go to DONE, valid=0.
  - DONE: busy=1, o_dump_done=1 for exactly one cycle, then IDLE.
- i_dump_start is ignored outside IDLE. A start held high in IDLE after DONE begins a new dump.
- A beat is exactly one cycle when ready is held high. A full dump takes N_REGS beats plus 1 DONE cycle, 33 cycles from the start edge to the done pulse.
- Reset mid-dump aborts immediately: valid=0, busy=0, no done pulse.

Test Plan:
- Reset, then read ports A=5, B=0 -> both read 0. Write 0xDEADBEEF to r5; the next cycle A=5 reads 0xDEADBEEF.
- Write 0x12345678 to r0, then read r0 -> 0. Bypass with i_wr_enable=1, addr 7, data 0xA5A5A5A5, both read ports on 7 in the same cycle -> both ports show 0xA5A5A5A5 before the edge.
- Load r_i = i*3 for i=1..31; pulse dump_start with ready held 1 -> 32 consecutive beats, addr 0..31, data 0,3,...,93; done pulses once in cycle 33; busy low after.
- Dump with ready toggling 1,0,0,1 -> addr/data hold stable while ready=0; no beat is skipped or duplicated; total 32 accepted beats.
- During a dump with ready=0 on beat 10, write 0x55 to r10 and r11 -> beat 10 still shows the old r10; after acceptance, beat 11 shows 0x55.
- Assert reset at beat 15 -> valid, busy, done = 0 next cycle; all registers read 0. A new start then restarts from addr 0.

Source files
------------

// File: rtl/wb_register_file_if.sv
// Bus bundle between writeback/decode/debug and the register file.
// Latency: n/a (wires only). Backpressure: dump beats stall on i_dump_ready.
// Ports: write port (i_wr_*), read ports A/B (i_rd_addr_*, o_rd_data_*),
//        dump stream (i_dump_start, i_dump_ready, o_dump_*).
interface wb_register_file_if #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 5
);
  logic               i_wr_enable;
  logic [NB_ADDR-1:0] i_wr_addr;
  logic [NB_DATA-1:0] i_wr_data;
  logic [NB_ADDR-1:0] i_rd_addr_a;
  logic [NB_ADDR-1:0] i_rd_addr_b;
  logic [NB_DATA-1:0] o_rd_data_a;
  logic [NB_DATA-1:0] o_rd_data_b;
  logic               i_dump_start;
  logic               i_dump_ready;
  logic               o_dump_valid;
  logic [NB_ADDR-1:0] o_dump_addr;
  logic [NB_DATA-1:0] o_dump_data;
  logic               o_dump_busy;
  logic               o_dump_done;

  // Driver side: writeback, decode and debug unit.
  modport master (
    output i_wr_enable, i_wr_addr, i_wr_data,
    output i_rd_addr_a, i_rd_addr_b,
    input  o_rd_data_a, o_rd_data_b,
    output i_dump_start, i_dump_ready,
    input  o_dump_valid, o_dump_addr, o_dump_data, o_dump_busy, o_dump_done
  );

  // Register file side.
  modport slave (
    input  i_wr_enable, i_wr_addr, i_wr_data,
    input  i_rd_addr_a, i_rd_addr_b,
    output o_rd_data_a, o_rd_data_b,
    input  i_dump_start, i_dump_ready,
    output o_dump_valid, o_dump_addr, o_dump_data, o_dump_busy, o_dump_done
  );
endinterface

// File: rtl/wb_register_file.sv
// 32-entry GPR file with write-to-read bypass and a ready/valid register dump streamer.
// Latency: reads are combinational (0 cycles); writes land on the next edge; dump beat registered.
// Backpressure: dump beat holds addr/data stable until i_dump_ready; writes are never stalled.
// Ports: i_clk, i_reset (sync, active high); bus (slave modport of wb_register_file_if).
module wb_register_file #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 5,
  parameter int N_REGS  = 32
) (
  input  logic                i_clk,
  input  logic                i_reset,
  wb_register_file_if.slave   bus
);

  localparam logic [NB_ADDR-1:0] LAST_IDX = NB_ADDR'(N_REGS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  logic [NB_DATA-1:0] regs [N_REGS];

  state_t             state_q, state_d;
  logic [NB_ADDR-1:0] dump_addr_q, dump_addr_d;
  logic [NB_DATA-1:0] dump_data_q, dump_data_d;
  logic [NB_ADDR-1:0] next_idx;
  logic               wr_hit_a, wr_hit_b;

  // ---------------------------------------------------------------
  // Register array. Register 0 is never written, so it stays 0.
  // ---------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < N_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.i_wr_enable && (bus.i_wr_addr != '0)) begin
      regs[bus.i_wr_addr] <= bus.i_wr_data;
    end
  end

  // ---------------------------------------------------------------
  // Read ports: a write in flight this cycle is forwarded so decode
  // sees the value that will be in the array after the edge.
  // ---------------------------------------------------------------
  assign wr_hit_a = bus.i_wr_enable && (bus.i_wr_addr == bus.i_rd_addr_a);
  assign wr_hit_b = bus.i_wr_enable && (bus.i_wr_addr == bus.i_rd_addr_b);

  assign bus.o_rd_data_a = (bus.i_rd_addr_a == '0) ? '0 :
                           wr_hit_a ? bus.i_wr_data : regs[bus.i_rd_addr_a];
  assign bus.o_rd_data_b = (bus.i_rd_addr_b == '0) ? '0 :
                           wr_hit_b ? bus.i_wr_data : regs[bus.i_rd_addr_b];

  // ---------------------------------------------------------------
  // Dump sequencer. The beat index lives in dump_addr_q itself.
  // ---------------------------------------------------------------
  assign next_idx = dump_addr_q + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      dump_addr_q <= '0;
      dump_data_q <= '0;
    end else begin
      state_q     <= state_d;
      dump_addr_q <= dump_addr_d;
      dump_data_q <= dump_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dump_addr_d = dump_addr_q;
    dump_data_d = dump_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_dump_start) begin
          state_d     = ST_SEND;
          dump_addr_d = '0;
          dump_data_d = regs[0];
        end
      end
      ST_SEND: begin
        if (bus.i_dump_ready) begin
          if (dump_addr_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            // Stored value only: a write on this same edge is not forwarded.
            dump_addr_d = next_idx;
            dump_data_d = regs[next_idx];
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.o_dump_valid = (state_q == ST_SEND);
  assign bus.o_dump_busy  = (state_q == ST_SEND) || (state_q == ST_DONE);
  assign bus.o_dump_done  = (state_q == ST_DONE);
  assign bus.o_dump_addr  = dump_addr_q;
  assign bus.o_dump_data  = dump_data_q;

endmodule

// File: tb/tb_wb_register_file.sv
// Self-checking bench for wb_register_file: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the register file and dump stream.
// Inputs change 1ns after the rising edge; outputs are compared on the falling edge.
module tb_wb_register_file;
  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 5;
  localparam int N_REGS  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wb_register_file_if #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) bus ();

  wb_register_file #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .N_REGS(N_REGS)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_beat: -1 = no dump, 0..31 = beat being offered, 32 = done cycle.
  logic [31:0] m_regs [N_REGS];
  int          m_beat  = -1;
  logic [4:0]  m_daddr = '0;
  logic [31:0] m_ddata = '0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REGS; i++) m_regs[i] = '0;
      m_beat  = -1;
      m_daddr = '0;
      m_ddata = '0;
    end else begin
      if (m_beat < 0) begin
        if (bus.i_dump_start) begin
          m_beat  = 0;
          m_daddr = '0;
          m_ddata = m_regs[0];
        end
      end else if (m_beat < N_REGS) begin
        if (bus.i_dump_ready) begin
          if (m_beat == N_REGS - 1) begin
            m_beat = N_REGS;
          end else begin
            m_beat  = m_beat + 1;
            m_daddr = 5'(m_beat);
            m_ddata = m_regs[m_beat];   // value before this edge's write
          end
        end
      end else begin
        m_beat = -1;
      end
      if (bus.i_wr_enable && bus.i_wr_addr != 0) m_regs[bus.i_wr_addr] = bus.i_wr_data;
    end
  end

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 0) return '0;
    if (bus.i_wr_enable && bus.i_wr_addr == a) return bus.i_wr_data;
    return m_regs[a];
  endfunction

  // ---------------- compare process + beat recorder ----------------
  logic [4:0]  q_addr [$];
  logic [31:0] q_data [$];
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("rd_a", bus.o_rd_data_a, exp_read(bus.i_rd_addr_a));
      check("rd_b", bus.o_rd_data_b, exp_read(bus.i_rd_addr_b));
      check("dump_valid", {31'b0, bus.o_dump_valid}, {31'b0, (m_beat >= 0 && m_beat < N_REGS)});
      check("dump_busy",  {31'b0, bus.o_dump_busy},  {31'b0, (m_beat >= 0)});
      check("dump_done",  {31'b0, bus.o_dump_done},  {31'b0, (m_beat == N_REGS)});
      if (m_beat >= 0 && m_beat < N_REGS) begin
        check("dump_addr", {27'b0, bus.o_dump_addr}, {27'b0, m_daddr});
        check("dump_data", bus.o_dump_data, m_ddata);
      end
      if (!rst && bus.o_dump_valid && bus.i_dump_ready) begin
        q_addr.push_back(bus.o_dump_addr);
        q_data.push_back(bus.o_dump_data);
      end
      if (bus.o_dump_done) done_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (bus.o_dump_busy && n < 100) begin
      step();
      n++;
    end
    check(nm, {31'b0, bus.o_dump_busy}, 32'd0);
  endtask

  // Verify recorded beats are 0..31 in order with data i*3.
  task automatic check_beats(input string nm);
    int errs = 0;
    check({nm, "_count"}, q_addr.size(), 32);
    foreach (q_addr[i]) begin
      if (q_addr[i] != 5'(i) || q_data[i] != 32'(i * 3)) errs++;
    end
    check({nm, "_seq_errs"}, errs, 0);
  endtask

  initial begin
    int          n;
    int          errs;
    logic [3:0]  pat;
    bus.i_wr_enable  = 1'b0;
    bus.i_wr_addr    = '0;
    bus.i_wr_data    = '0;
    bus.i_rd_addr_a  = 5'd5;
    bus.i_rd_addr_b  = 5'd0;
    bus.i_dump_start = 1'b0;
    bus.i_dump_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk_en = 1'b1;
    #1;

    // Reset state.
    check("reset_rd_a5", bus.o_rd_data_a, 32'h0);
    check("reset_rd_b0", bus.o_rd_data_b, 32'h0);
    check("reset_busy", {31'b0, bus.o_dump_busy}, 32'd0);

    // Write r5, read next cycle.
    bus.i_wr_enable = 1'b1; bus.i_wr_addr = 5'd5; bus.i_wr_data = 32'hDEADBEEF;
    step();
    bus.i_wr_enable = 1'b0;
    #1;
    check("r5_after_write", bus.o_rd_data_a, 32'hDEADBEEF);

    // Write to r0 is discarded.
    bus.i_wr_enable = 1'b1; bus.i_wr_addr = 5'd0; bus.i_wr_data = 32'h12345678;
    bus.i_rd_addr_a = 5'd0;
    step();
    bus.i_wr_enable = 1'b0;
    #1;
    check("r0_stays_zero", bus.o_rd_data_a, 32'h0);

    // Same-cycle bypass on both ports.
    bus.i_wr_enable = 1'b1; bus.i_wr_addr = 5'd7; bus.i_wr_data = 32'hA5A5A5A5;
    bus.i_rd_addr_a = 5'd7; bus.i_rd_addr_b = 5'd7;
    #1;
    check("bypass_a", bus.o_rd_data_a, 32'hA5A5A5A5);
    check("bypass_b", bus.o_rd_data_b, 32'hA5A5A5A5);
    step();

    // Load r_i = 3*i.
    for (int i = 1; i < N_REGS; i++) begin
      bus.i_wr_enable = 1'b1; bus.i_wr_addr = 5'(i); bus.i_wr_data = 32'(i * 3);
      step();
    end
    bus.i_wr_enable = 1'b0;

    // Dump 1: ready held high, done lands in cycle 33.
    q_addr.delete(); q_data.delete(); done_cnt = 0;
    bus.i_dump_ready = 1'b1;
    bus.i_dump_start = 1'b1;
    step();
    bus.i_dump_start = 1'b0;
    n = 0;
    while (!bus.o_dump_done && n < 60) begin
      step();
      n++;
    end
    check("dump1_done_cycle", n + 1, 33);
    step();
    check("dump1_busy_after", {31'b0, bus.o_dump_busy}, 32'd0);
    check("dump1_done_pulses", done_cnt, 1);
    check_beats("dump1");

    // Dump 2: ready pattern 1,0,0,1.
    q_addr.delete(); q_data.delete(); done_cnt = 0;
    pat = 4'b1001;
    bus.i_dump_start = 1'b1;
    bus.i_dump_ready = pat[0];
    step();
    bus.i_dump_start = 1'b0;
    n = 1;
    while (bus.o_dump_busy && n < 200) begin
      bus.i_dump_ready = pat[n % 4];
      step();
      n++;
    end
    check("dump2_finished", {31'b0, bus.o_dump_busy}, 32'd0);
    check("dump2_done_pulses", done_cnt, 1);
    check_beats("dump2");

    // Dump 3: writes to r10/r11 while beat 10 is stalled.
    bus.i_dump_ready = 1'b1;
    bus.i_dump_start = 1'b1;
    step();
    bus.i_dump_start = 1'b0;
    n = 0;
    while (bus.o_dump_addr != 5'd10 && n < 40) begin
      step();
      n++;
    end
    bus.i_dump_ready = 1'b0;
    bus.i_wr_enable = 1'b1; bus.i_wr_addr = 5'd10; bus.i_wr_data = 32'h55;
    step();
    bus.i_wr_addr = 5'd11;
    step();
    bus.i_wr_enable = 1'b0;
    #1;
    check("beat10_addr_hold", {27'b0, bus.o_dump_addr}, 32'd10);
    check("beat10_old_data", bus.o_dump_data, 32'd30);
    bus.i_dump_ready = 1'b1;
    step();
    check("beat11_addr", {27'b0, bus.o_dump_addr}, 32'd11);
    check("beat11_new_data", bus.o_dump_data, 32'h55);
    wait_idle("dump3_timeout");

    // Dump 4: reset at beat 15, then restart.
    bus.i_dump_start = 1'b1;
    step();
    bus.i_dump_start = 1'b0;
    n = 0;
    while (bus.o_dump_addr != 5'd15 && n < 40) begin
      step();
      n++;
    end
    check("dump4_reached_15", {27'b0, bus.o_dump_addr}, 32'd15);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_valid", {31'b0, bus.o_dump_valid}, 32'd0);
    check("rst_busy",  {31'b0, bus.o_dump_busy},  32'd0);
    check("rst_done",  {31'b0, bus.o_dump_done},  32'd0);
    errs = 0;
    for (int i = 0; i < N_REGS; i++) begin
      bus.i_rd_addr_a = 5'(i);
      #1;
      if (bus.o_rd_data_a !== 32'h0) errs++;
    end
    check("rst_regs_zero_errs", errs, 0);
    bus.i_dump_start = 1'b1;
    step();
    bus.i_dump_start = 1'b0;
    check("restart_valid", {31'b0, bus.o_dump_valid}, 32'd1);
    check("restart_addr", {27'b0, bus.o_dump_addr}, 32'd0);
    wait_idle("dump4_timeout");

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      bus.i_wr_enable  = ($urandom_range(0, 1) == 1);
      bus.i_wr_addr    = 5'($urandom_range(0, 31));
      bus.i_wr_data    = $urandom;
      bus.i_rd_addr_a  = ($urandom_range(0, 3) == 0) ? bus.i_wr_addr : 5'($urandom_range(0, 31));
      bus.i_rd_addr_b  = ($urandom_range(0, 3) == 0) ? bus.i_wr_addr : 5'($urandom_range(0, 31));
      bus.i_dump_start = ($urandom_range(0, 15) == 0);
      bus.i_dump_ready = ($urandom_range(0, 2) != 0);
      rst              = ($urandom_range(0, 599) == 0);
      step();
    end
    rst = 1'b0;
    bus.i_dump_start = 1'b0;
    bus.i_dump_ready = 1'b1;
    bus.i_wr_enable  = 1'b0;
    step();
    wait_idle("random_drain_timeout");
    @(negedge clk);
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
